// File: rtl/vga_pkg.sv
// Shared types and constants for the camera-to-SDRAM write path: FSM encoding,
// default burst/frame geometry and the configuration sanity checks.
package vga_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int BURST_LEN    = 8;
  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;
  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

  function automatic bit is_pow2(input int v);
    return (v > 1) && ((v & (v - 1)) == 0);
  endfunction

  // A frame must split into whole bursts and pixels must map 1:1 onto SDRAM words.
  function automatic bit cfg_ok(input int pix_w, input int word_w, input int burst,
                                input int pixels);
    return (pix_w == word_w) && is_pow2(burst) && ((pixels % burst) == 0);
  endfunction

endpackage

// File: rtl/sdram_burst_writer_buffer.sv
// Burst staging register file: written from the FIFO side by capture index,
// read combinationally by the SDRAM side word index.
module burst_buffer #(
  parameter int Depth    = 8,
  parameter int Width    = 16,
  parameter int IdxWidth = 3
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IdxWidth-1:0] wr_idx,
  input  logic [Width-1:0]    wr_data,
  input  logic [IdxWidth-1:0] rd_idx,
  output logic [Width-1:0]    rd_data
);

  logic [Width-1:0] mem [Depth];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sdram_burst_writer.sv
// Drains the pixel FIFO into fixed-length bursts and issues each burst as one
// SDRAM write command, walking linear word addresses that wrap at frame end.
module sdram_burst_writer
  import vga_pkg::*;
#(
  parameter int PixelBitWidth     = 16,
  parameter int WordLengthSDRAM   = 16,
  parameter int AddressWidthSDRAM = 24,
  parameter int BurstLengthSDRAM  = BURST_LEN,
  parameter int FrameWidth        = FRAME_WIDTH,
  parameter int FrameHeight       = FRAME_HEIGHT
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_enable,
  input  logic                         i_fifo_empty,
  input  logic                         i_fifo_full,
  input  logic [PixelBitWidth-1:0]     i_fifo_data,
  output logic                         o_fifo_rd_en,
  input  logic                         i_sdram_busy,
  input  logic                         i_sdram_valid_wr,
  output logic                         o_sdram_enable,
  output logic                         o_sdram_rw,
  output logic [AddressWidthSDRAM-1:0] o_sdram_addr,
  output logic [WordLengthSDRAM-1:0]   o_sdram_data,
  output logic                         o_frame_done,
  output logic                         o_overflow,
  output state_t                       fsm_state
);

  localparam int IDX_W = $clog2(BurstLengthSDRAM);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BurstLengthSDRAM);
  localparam logic [CNT_W-1:0] LAST_CAP  = CNT_W'(BurstLengthSDRAM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BurstLengthSDRAM - 1);
  localparam logic [AddressWidthSDRAM-1:0] BURST_STEP = AddressWidthSDRAM'(BurstLengthSDRAM);
  localparam logic [AddressWidthSDRAM-1:0] LAST_ADDR  =
    AddressWidthSDRAM'(FrameWidth * FrameHeight - BurstLengthSDRAM);

  if (!cfg_ok(PixelBitWidth, WordLengthSDRAM, BurstLengthSDRAM, FrameWidth * FrameHeight))
  begin : g_bad_cfg
    $error("sdram_burst_writer: invalid width/burst/frame configuration");
  end

  state_t                       state, next_state;
  logic [CNT_W-1:0]             req_cnt, cap_cnt;
  logic [IDX_W-1:0]             word_idx;
  logic                         rd_pending;
  logic [AddressWidthSDRAM-1:0] wr_addr;
  logic [WordLengthSDRAM-1:0]   buf_rdata;
  logic                         last_cap, last_word, frame_end;

  // Leave FILL on the edge that captures the final word so ISSUE follows directly.
  assign last_cap  = rd_pending && (cap_cnt == LAST_CAP);
  assign last_word = (state == WRITE) && i_sdram_valid_wr && (word_idx == LAST_IDX);
  assign frame_end = last_word && (wr_addr == LAST_ADDR);

  always_ff @(posedge CLK) begin
    if (RST) state <= FILL;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (last_cap) next_state = ISSUE;
      ISSUE:   if (!i_sdram_busy) next_state = WRITE;
      WRITE:   if (last_word) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // A started burst keeps reading after i_enable drops (req_cnt != 0), and no
  // read is requested while RST is held so every output is quiet in reset.
  always_comb begin
    o_fifo_rd_en   = 1'b0;
    o_sdram_enable = 1'b0;
    o_sdram_data   = '0;
    o_frame_done   = 1'b0;
    case (state)
      FILL:  o_fifo_rd_en = !RST && !i_fifo_empty && (req_cnt < BURST_CNT) &&
                            (i_enable || (req_cnt != '0));
      ISSUE: o_sdram_enable = !i_sdram_busy;
      WRITE: begin
        o_sdram_data = buf_rdata;
        o_frame_done = frame_end;
      end
      default: ;
    endcase
  end

  assign o_sdram_rw   = 1'b0;
  assign o_sdram_addr = wr_addr;
  assign fsm_state    = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_cnt    <= '0;
      cap_cnt    <= '0;
      word_idx   <= '0;
      rd_pending <= 1'b0;
      wr_addr    <= '0;
    end else begin
      rd_pending <= o_fifo_rd_en;
      if (o_fifo_rd_en) req_cnt <= req_cnt + 1'b1;
      if (rd_pending)   cap_cnt <= cap_cnt + 1'b1;
      if ((state == WRITE) && i_sdram_valid_wr) begin
        if (word_idx == LAST_IDX) begin
          word_idx <= '0;
          req_cnt  <= '0;
          cap_cnt  <= '0;
          wr_addr  <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + BURST_STEP;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)              o_overflow <= 1'b0;
    else if (i_fifo_full) o_overflow <= 1'b1;
  end

  burst_buffer #(
    .Depth    (BurstLengthSDRAM),
    .Width    (WordLengthSDRAM),
    .IdxWidth (IDX_W)
  ) u_buffer (
    .clk     (CLK),
    .wr_en   (rd_pending),
    .wr_idx  (cap_cnt[IDX_W-1:0]),
    .wr_data (i_fifo_data),
    .rd_idx  (word_idx),
    .rd_data (buf_rdata)
  );

endmodule

// File: doc/sdram_burst_writer.md
# sdram_burst_writer

Drains camera pixels from the pixel-clock/system-clock FIFO and packs them into fixed-length bursts. It then issues each burst as one SDRAM write command. Sits between the `fifo_generator_0` read port and the `SDRAM` controller's write side, in the `CLK` domain. It generates linear word addresses for a full frame and wraps at frame end.

## Interface
- `PixelBitWidth`, 16, FIFO word width; must equal `WordLengthSDRAM`.
- `WordLengthSDRAM`, 16, SDRAM data word width.
- `AddressWidthSDRAM`, 24, SDRAM word-address width.
- `BurstLengthSDRAM`, 8, words per burst; power of two.
- `FrameWidth`, 640, pixels per line.
- `FrameHeight`, 480, lines per frame; `FrameWidth*FrameHeight` must be a multiple of `BurstLengthSDRAM`.

Ports:
- `CLK` in 1: system clock; one clock domain only.
- `RST` in 1: synchronous, active-high reset.
- `i_enable` in 1: allows new bursts to start.
- `i_fifo_empty` in 1: FIFO empty flag.
- `i_fifo_full` in 1: FIFO full flag.
- `i_fifo_data` in PixelBitWidth: FIFO `dout`; valid the cycle after `o_fifo_rd_en`.
- `o_fifo_rd_en` out 1: FIFO read strobe.
- `i_sdram_busy` in 1: controller cannot accept a command.
- `i_sdram_valid_wr` in 1: controller consumes `o_sdram_data` this cycle.
- `o_sdram_enable` out 1: one-cycle command strobe.
- `o_sdram_rw` out 1: always 0 (write).
- `o_sdram_addr` out AddressWidthSDRAM: burst start word address.
- `o_sdram_data` out WordLengthSDRAM: current burst word.
- `o_frame_done` out 1: one-cycle pulse when the last word of a frame is consumed.
- `o_overflow` out 1: sticky; set when `i_fifo_full` is sampled high.

## Operation
- The state machine has three states: FILL, ISSUE, WRITE.
- **FILL**
  - `o_fifo_rd_en = !i_fifo_empty && req_cnt < BurstLengthSDRAM && (i_enable || req_cnt != 0)`.
  - `o_fifo_rd_en` is combinational.
  - A registered `rd_pending` flag marks that `i_fifo_data` is valid next cycle. That word is written to `buf[cap_cnt]`, then `cap_cnt` increments.
  - When `cap_cnt` reaches `BurstLengthSDRAM`, go to ISSUE.
  - Once a burst has begun filling, it completes even if `i_enable` drops. Deasserting `i_enable` never leaves a partial burst.
- **ISSUE**
  - When `i_sdram_busy=0`: `o_sdram_enable=1` for exactly one cycle, `o_sdram_addr=wr_addr`, then go to WRITE.
  - While busy: hold with `o_sdram_enable=0`.
- **WRITE**
  - `o_sdram_data=buf[word_idx]`.
  - On each cycle with `i_sdram_valid_wr=1`, `word_idx` increments.
  - `i_sdram_valid_wr` on the last index does all of the following:
    - `wr_addr += BurstLengthSDRAM`
    - clear `req_cnt`, `cap_cnt` and `word_idx`
    - return to FILL
  - `i_sdram_valid_wr` outside WRITE is ignored.
- **Address rule**
  - `wr_addr` counts 0 … `FrameWidth*FrameHeight-BurstLengthSDRAM` in steps of `BurstLengthSDRAM`.
  - After the final burst of a frame, `wr_addr` wraps to 0 and `o_frame_done` pulses in the same cycle as the final `i_sdram_valid_wr`.
  - Arithmetic is unsigned at `AddressWidthSDRAM` width.
- **Overflow:** `o_overflow` is set on any cycle with `i_fifo_full=1`. It is cleared only by `RST`. It does not change the data path.
- **Reset:**
  - All outputs are 0 and state is FILL.
  - All counters and `wr_addr` are 0 and `rd_pending` is 0.
  - Buffer contents are don't-care.
  - Reset mid-burst discards the buffered words. The FIFO word already requested is dropped.

## Timing
- FIFO read latency is 1 cycle (standard, non-FWFT mode).
- With ≥8 words in the FIFO and the SDRAM idle:
  - `o_fifo_rd_en` high in cycles 0–7.
  - Captures in cycles 1–8.
  - ISSUE in cycle 9, with `o_sdram_enable` high in cycle 9.
  - WRITE from cycle 10.
- Minimum burst turnaround is `BurstLengthSDRAM + 2` cycles plus the controller's write latency. FILL does not overlap WRITE.
- `o_sdram_data` changes only on the edge where `i_sdram_valid_wr` is sampled high. It is stable from cycle 10 onward.
- If the FIFO empties mid-fill, `o_fifo_rd_en` drops. The fill resumes, without losing or duplicating words, when the FIFO refills.

## Structure
- Shared package `vga_pkg` holds:
  - the state encoding (FILL/ISSUE/WRITE)
  - `BURST_LEN = 8`
  - `FRAME_PIXELS = FrameWidth*FrameHeight`
  - the compile-time checks: `PixelBitWidth == WordLengthSDRAM`, power-of-two burst, frame divisible by burst
- Natural sub-module: `burst_buffer`.
  - `BurstLengthSDRAM × WordLengthSDRAM` register file.
  - One write port indexed by `cap_cnt`, one read port indexed by `word_idx`.
- The FSM, counters and address generator stay in the top.

## Test plan
- **Single burst:** FIFO preloaded with 0x0001–0x0008, SDRAM idle, `i_sdram_valid_wr` high continuously.
  - `o_sdram_enable` is high in cycle 9 only, with addr 0.
  - `o_sdram_data` is 0x0001…0x0008 in order.
  - Second burst uses addr 8.
- **Busy stall:** `i_sdram_busy=1` for 5 cycles at ISSUE.
  - `o_sdram_enable` stays 0, then pulses exactly once.
  - Address is unchanged.
- **Starved FIFO:** `i_fifo_empty` toggles every 2 cycles during the fill.
  - Exactly 8 distinct words are captured, in FIFO order.
  - No `o_fifo_rd_en` is asserted while `i_fifo_empty=1`.
- **Frame wrap:** 38400 bursts with `FrameWidth=640`, `FrameHeight=480`.
  - Last address is 307192.
  - `o_frame_done` pulses once.
  - Next burst uses addr 0.
- **Reset mid-WRITE:** `RST` asserted after 3 words are consumed.
  - Next cycle: all outputs 0, address 0.
  - The next burst starts from a fresh FIFO word.
- **Overflow and enable:**
  - `i_fifo_full` pulsed 1 cycle: `o_overflow` is 1 and stays set until `RST`.
  - `i_enable` dropped mid-fill: the burst completes and no new reads follow.
